// File: rtl/bin2bcd_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_if
//
// Purpose: groups the conversion handshake of the bin2bcd converter into a
// single bundle. The producer of binary values uses the master modport and
// the converter itself uses the slave modport.
//
// Signals:
//   i_Binary  [INPUT_WIDTH]      unsigned value to convert (master -> slave)
//   i_Start   [1]                start request            (master -> slave)
//   o_BCD     [DECIMAL_DIGITS*4] packed BCD result, units in bits [3:0]
//                                                         (slave -> master)
//   o_DV      [1]                one-cycle "new result" pulse
//                                                         (slave -> master)
// ---------------------------------------------------------------------------
interface bin2bcd_if #(
    parameter int INPUT_WIDTH    = 16,
    parameter int DECIMAL_DIGITS = 5
);

    logic [INPUT_WIDTH-1:0]      i_Binary;
    logic                        i_Start;
    logic [DECIMAL_DIGITS*4-1:0] o_BCD;
    logic                        o_DV;

    modport master (
        output i_Binary,
        output i_Start,
        input  o_BCD,
        input  o_DV
    );

    modport slave (
        input  i_Binary,
        input  i_Start,
        output o_BCD,
        output o_DV
    );

endinterface

// File: rtl/bin2bcd.sv
// ---------------------------------------------------------------------------
// bin2bcd
//
// Purpose: sequential binary-to-BCD converter using shift-and-add-3
// (double dabble). Each input bit costs one ADD cycle and one SHIFT cycle,
// followed by a single DONE cycle that publishes the result. The result on
// o_BCD is held until the next conversion completes.
//
// Ports:
//   i_Clock   system clock, rising-edge active
//   i_Reset   asynchronous active-high reset; aborts any conversion
//   bus       bin2bcd_if slave modport:
//               i_Binary  value to convert, latched when a start is accepted
//               i_Start   start request, only honoured while idle
//               o_BCD     packed BCD result (digit k in bits [4k+3:4k])
//               o_DV      one-cycle pulse when o_BCD has just been updated
// ---------------------------------------------------------------------------
module bin2bcd #(
    parameter int INPUT_WIDTH    = 16,
    parameter int DECIMAL_DIGITS = 5
) (
    input logic     i_Clock,
    input logic     i_Reset,
    bin2bcd_if.slave bus
);

    localparam int BCD_W = DECIMAL_DIGITS * 4;
    localparam int CNT_W = $clog2(INPUT_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(INPUT_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] binary_q, binary_d;
    logic [BCD_W-1:0]       scratch_q, scratch_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   dv_q, dv_d;

    logic [BCD_W-1:0]       scratch_adj;
    logic [CNT_W-1:0]       count_inc;

    // Add-3 correction applied to every digit in parallel. Digits are
    // corrected independently; a corrected digit never exceeds 4'hC, so no
    // carry between digits is needed.
    always_comb begin
        scratch_adj = scratch_q;
        for (int k = 0; k < DECIMAL_DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    assign count_inc = count_q + CNT_W'(1);

    // Next-state and datapath control. o_DV defaults low so it can only be
    // high for the single cycle following DONE.
    always_comb begin
        state_d   = state_q;
        binary_d  = binary_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
        dv_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_Start) begin
                    binary_d  = bus.i_Binary;
                    scratch_d = '0;
                    count_d   = '0;
                    state_d   = ADD;
                end
            end

            ADD: begin
                scratch_d = scratch_adj;
                state_d   = SHIFT;
            end

            SHIFT: begin
                // The binary MSB moves into the scratch LSB; the scratch MSB
                // falls off, which yields the value modulo 10^DECIMAL_DIGITS
                // when there are too few digits.
                scratch_d = {scratch_q[BCD_W-2:0], binary_q[INPUT_WIDTH-1]};
                binary_d  = binary_q << 1;
                count_d   = count_inc;
                if (count_inc == LAST_BIT) begin
                    state_d = DONE;
                end else begin
                    state_d = ADD;
                end
            end

            DONE: begin
                bcd_d   = scratch_q;
                dv_d    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything, so an aborted
    // conversion leaves no trace and never produces a data-valid pulse.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            binary_q  <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            binary_q  <= binary_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
            dv_q      <= dv_d;
        end
    end

    assign bus.o_BCD = bcd_q;
    assign bus.o_DV  = dv_q;

endmodule

// File: tb/tb_bin2bcd.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd
//
// Purpose: self-checking bench for bin2bcd. Drives a 16-bit/5-digit instance
// through a table of conversions and several multi-cycle sequences, plus an
// 8-bit/2-digit instance to exercise the digit-overflow case.
// ---------------------------------------------------------------------------
module tb_bin2bcd;

    logic clk;
    logic rst;

    int total;
    int bad;

    bin2bcd_if #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5)) bus ();
    bin2bcd_if #(.INPUT_WIDTH(8),  .DECIMAL_DIGITS(2)) busSmall ();

    bin2bcd #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus.slave)
    );

    bin2bcd #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(2)) dutSmall (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (busSmall.slave)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
    } vec_t;

    vec_t vecs [9];

    // Compare one value and log a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a value with a one-cycle start pulse; returns after the
    // accepting edge with i_Start low again
    task automatic applyStimulus(input logic [15:0] value);
        @(negedge clk);
        bus.i_Binary = value;
        bus.i_Start  = 1'b1;
        @(posedge clk);
        #1 bus.i_Start = 1'b0;
    endtask

    // Count rising edges until o_DV is seen high (sampled at negedge);
    // returns -1 if it never arrives within the budget
    task automatic waitDv(output int cycles);
        int c;
        c = 0;
        cycles = -1;
        while (c < 100) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (bus.o_DV === 1'b1) begin
                cycles = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int firstAt;

        total = 0;
        bad   = 0;

        vecs[0] = '{16'd123,   20'h00123};
        vecs[1] = '{16'd999,   20'h00999};
        vecs[2] = '{16'd4096,  20'h04096};
        vecs[3] = '{16'd32767, 20'h32767};
        vecs[4] = '{16'd65535, 20'h65535};
        vecs[5] = '{16'd10000, 20'h10000};
        vecs[6] = '{16'd5432,  20'h05432};
        vecs[7] = '{16'd888,   20'h00888};
        vecs[8] = '{16'd42,    20'h00042};

        bus.i_Binary      = '0;
        bus.i_Start       = 1'b0;
        busSmall.i_Binary = '0;
        busSmall.i_Start  = 1'b0;
        rst = 1'b1;
        #23;

        // Reset state
        checkOutput("reset_bcd", 32'(bus.o_BCD), 32'h0);
        checkOutput("reset_dv",  32'(bus.o_DV),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Zero input, latency check
        applyStimulus(16'd0);
        waitDv(lat);
        checkOutput("zero_latency", 32'(lat), 32'd33);
        checkOutput("zero_bcd", 32'(bus.o_BCD), 32'h0);

        // Table of conversions, each with a one-cycle o_DV
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].bin);
            waitDv(lat);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
            checkOutput($sformatf("vec%0d_bcd", i), 32'(bus.o_BCD), 32'(vecs[i].bcd));
            @(negedge clk);
            checkOutput($sformatf("vec%0d_dv_width", i), 32'(bus.o_DV), 32'h0);
            checkOutput($sformatf("vec%0d_bcd_hold", i), 32'(bus.o_BCD), 32'(vecs[i].bcd));
        end

        // Starts and input changes during a conversion are ignored
        applyStimulus(16'd42);
        pulses  = 0;
        firstAt = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_DV === 1'b1) begin
                pulses++;
                if (firstAt < 0) firstAt = c;
            end
            bus.i_Binary = 16'd999;
            bus.i_Start  = (c < 28) ? c[0] : 1'b0;
        end
        checkOutput("ignore_pulses", 32'(pulses), 32'd1);
        checkOutput("ignore_latency", 32'(firstAt), 32'd33);
        checkOutput("ignore_bcd", 32'(bus.o_BCD), 32'h00042);

        // Start held high: back-to-back conversions 34 cycles apart
        @(negedge clk);
        bus.i_Binary = 16'd888;
        bus.i_Start  = 1'b1;
        waitDv(lat);
        checkOutput("held_first_bcd", 32'(bus.o_BCD), 32'h00888);
        waitDv(lat);
        checkOutput("held_spacing1", 32'(lat), 32'd34);
        checkOutput("held_second_bcd", 32'(bus.o_BCD), 32'h00888);
        waitDv(lat);
        bus.i_Start = 1'b0;
        checkOutput("held_spacing2", 32'(lat), 32'd34);
        checkOutput("held_third_bcd", 32'(bus.o_BCD), 32'h00888);

        // Reset aborts a conversion in progress
        applyStimulus(16'd5432);
        waitDv(lat);
        checkOutput("abort_pre_bcd", 32'(bus.o_BCD), 32'h05432);
        applyStimulus(16'd65535);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_bcd", 32'(bus.o_BCD), 32'h0);
        checkOutput("abort_dv",  32'(bus.o_DV),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.o_DV === 1'b1) pulses++;
        end
        checkOutput("abort_no_dv", 32'(pulses), 32'd0);
        applyStimulus(16'd123);
        waitDv(lat);
        checkOutput("abort_after_latency", 32'(lat), 32'd33);
        checkOutput("abort_after_bcd", 32'(bus.o_BCD), 32'h00123);

        // Narrow instance: 255 with two digits wraps to 55
        @(negedge clk);
        busSmall.i_Binary = 8'd255;
        busSmall.i_Start  = 1'b1;
        @(posedge clk);
        #1 busSmall.i_Start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (busSmall.o_DV === 1'b1) begin
                lat = c;
                break;
            end
        end
        checkOutput("small_latency", 32'(lat), 32'd17);
        checkOutput("small_bcd", 32'(busSmall.o_BCD), 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
